// File: rtl/set_job_arbiter_if.sv
// Bus bundle for set_job_arbiter: two job request channels, the engine
// en/busy/valid channel and the response valid/ready channel.
// master = arbiter side, slave = requesters/engine/consumer side.
interface set_job_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [23:0] req0_central;
    logic [11:0] req0_radius;
    logic [1:0]  req0_mode;

    logic        req1_valid;
    logic        req1_ready;
    logic [23:0] req1_central;
    logic [11:0] req1_radius;
    logic [1:0]  req1_mode;

    logic        eng_en;
    logic [23:0] eng_central;
    logic [11:0] eng_radius;
    logic [1:0]  eng_mode;
    logic        eng_busy;
    logic        eng_valid;
    logic [7:0]  eng_candidate;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [7:0]  rsp_candidate;
    logic        rsp_err;

    modport master (
        input  req0_valid, req0_central, req0_radius, req0_mode,
        output req0_ready,
        input  req1_valid, req1_central, req1_radius, req1_mode,
        output req1_ready,
        output eng_en, eng_central, eng_radius, eng_mode,
        input  eng_busy, eng_valid, eng_candidate,
        output rsp_valid, rsp_id, rsp_candidate, rsp_err,
        input  rsp_ready
    );

    modport slave (
        output req0_valid, req0_central, req0_radius, req0_mode,
        input  req0_ready,
        output req1_valid, req1_central, req1_radius, req1_mode,
        input  req1_ready,
        input  eng_en, eng_central, eng_radius, eng_mode,
        output eng_busy, eng_valid, eng_candidate,
        input  rsp_valid, rsp_id, rsp_candidate, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/set_job_arbiter.sv
// set_job_arbiter: shares one SET circle-set counting engine between two
// requesters. Round-robin grant, one job in flight, result returned with the
// requester ID on a valid/ready response channel.
// Optional feature: define SET_ARB_WDOG_EN to add a per-job watchdog that
// aborts a job after WDOG_CYC engine cycles and flags it with rsp_err.
module set_job_arbiter #(
    parameter int CNT_W    = 16,
    parameter int WDOG_CYC = 4096
) (
    input  logic               clk,
    input  logic               rst,
    set_job_arbiter_if.master  bus,
    output logic [CNT_W-1:0]   job_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               ptr_q;
    logic               grant0;
    logic               grant1;
    logic               grant_any;
    logic               eng_en_c;
    logic               take_result;
    logic               timeout;
    logic [23:0]        central_q;
    logic [11:0]        radius_q;
    logic [1:0]         mode_q;
    logic               id_q;
    logic [7:0]         cand_q;
    logic [CNT_W-1:0]   cnt_q;

    // Grant selection: only in IDLE and out of reset; pointer breaks ties.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst && state_q == IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant1 = ptr_q;
                grant0 = ~ptr_q;
            end else if (bus.req0_valid) begin
                grant0 = 1'b1;
            end else if (bus.req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign grant_any   = grant0 | grant1;
    assign take_result = (state_q == WAIT) && bus.eng_valid;

`ifdef SET_ARB_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC) + 1;

    logic [WD_W-1:0] wdog_q;
    logic            err_q;

    // Watchdog: cleared when a job is granted (entry to ISSUE), counts in ISSUE/WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q <= '0;
        end else if (grant_any) begin
            wdog_q <= '0;
        end else if (state_q == ISSUE || state_q == WAIT) begin
            wdog_q <= wdog_q + 1'b1;
        end
    end

    assign timeout = (state_q == ISSUE || state_q == WAIT) &&
                     (wdog_q == WD_W'(WDOG_CYC - 1));

    // Abort flag: set on a watchdog expiry that is not beaten by a real result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (grant_any) begin
            err_q <= 1'b0;
        end else if (timeout && !take_result) begin
            err_q <= 1'b1;
        end
    end

    assign bus.rsp_err = err_q;
`else
    logic unused_wdog;

    assign unused_wdog = ^WDOG_CYC;
    assign timeout     = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and the single-cycle engine start pulse.
    always_comb begin
        state_d  = state_q;
        eng_en_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (timeout) begin
                    state_d = RESP;
                end else if (!bus.eng_busy) begin
                    eng_en_c = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (bus.eng_valid || timeout) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Job latch and round-robin pointer, both updated on a grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            central_q <= '0;
            radius_q  <= '0;
            mode_q    <= '0;
            id_q      <= 1'b0;
            ptr_q     <= 1'b0;
        end else if (grant_any) begin
            central_q <= grant1 ? bus.req1_central : bus.req0_central;
            radius_q  <= grant1 ? bus.req1_radius  : bus.req0_radius;
            mode_q    <= grant1 ? bus.req1_mode    : bus.req0_mode;
            id_q      <= grant1;
            ptr_q     <= ~grant1;
        end
    end

    // Result capture: engine count on the first valid in WAIT, zero on abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand_q <= '0;
        end else if (take_result) begin
            cand_q <= bus.eng_candidate;
        end else if (timeout) begin
            cand_q <= '0;
        end
    end

    // Completed-response counter, bumped on each response handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (state_q == RESP && bus.rsp_ready) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.req0_ready    = grant0;
    assign bus.req1_ready    = grant1;
    assign bus.eng_en        = eng_en_c;
    assign bus.eng_central   = central_q;
    assign bus.eng_radius    = radius_q;
    assign bus.eng_mode      = mode_q;
    assign bus.rsp_valid     = (state_q == RESP);
    assign bus.rsp_id        = id_q;
    assign bus.rsp_candidate = cand_q;
    assign job_cnt           = cnt_q;

endmodule

// File: doc/set_job_arbiter.md
Name: set_job_arbiter

Overview:
- Shares one SET circle-set counting engine between two independent requesters.
- Each requester submits a job: central coordinates, radii and set-operation mode.
- The block arbitrates round-robin and issues the job to the engine with the engine's en/busy protocol.
- It captures the engine's candidate count and returns it with the requester ID over a valid/ready response channel.

Parameters:
- CNT_W, 16: width of the completed-job counter.
- WDOG_CYC, 4096: maximum engine cycles allowed per job (used only with the optional feature).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a job.
- req0_ready  out  1  requester 0 job accepted this cycle (when valid is also high).
- req0_central  in  24  {x1,y1,x2,y2,x3,y3}, 4 bits each.
- req0_radius  in  12  {r1,r2,r3}, 4 bits each.
- req0_mode  in  2  00 A, 01 A|B, 10 A^B, 11 intersect.
- req1_valid, req1_ready, req1_central, req1_radius, req1_mode: same as requester 0.
- eng_en  out  1  one-cycle job start pulse to the engine.
- eng_central  out  24  job data to the engine; held stable from the eng_en cycle until eng_valid.
- eng_radius  out  12  job data to the engine; held the same way.
- eng_mode  out  2  job data to the engine; held the same way.
- eng_busy  in  1  engine busy.
- eng_valid  in  1  engine result valid.
- eng_candidate  in  8  engine result count.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that issued the job.
- rsp_candidate  out  8  captured count.
- rsp_err  out  1  watchdog abort flag; tied 0 without the optional feature.
- job_cnt  out  CNT_W  number of completed responses; wraps.

Behaviour:
- Reset (rst low, asynchronous): all outputs go to 0.
  - The FSM enters IDLE.
  - The round-robin pointer is set to 0, so requester 0 has priority first.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any reqX_valid is high, grant one requester.
  - When both are valid, grant the requester indicated by the pointer; otherwise grant the only valid one.
  - reqX_ready is asserted combinationally for the granted requester only. Job data, including mode, is latched on that edge.
  - Next state is ISSUE.
  - The pointer moves to the other requester after each grant.
  - reqX_ready is 0 in every other state; the block holds no queue and accepts one job at a time.
- ISSUE:
  - If eng_busy is 0, assert eng_en for exactly one cycle, then go to WAIT.
  - If eng_busy is 1, stay in ISSUE with eng_en at 0.
  - Latency from acceptance to eng_en is 1 cycle minimum.
- WAIT:
  - On the first cycle eng_valid is 1, capture eng_candidate into rsp_candidate and go to RESP.
  - eng_valid seen in ISSUE, or in the eng_en cycle itself, is ignored.
- RESP:
  - rsp_valid is 1, and rsp_id, rsp_candidate and rsp_err are stable.
  - On rsp_valid and rsp_ready together: job_cnt increments (modulo 2^CNT_W) and the FSM returns to IDLE.
  - Earliest next grant is the cycle after the handshake.
  - rsp_ready held high gives back-to-back operation with no extra bubble beyond IDLE.
- eng_central, eng_radius and eng_mode stay at the last job's values while idle.
- Reset mid-job: the FSM returns to IDLE immediately and eng_en drops. The engine is reset by its own rst; no response is produced.
- A requester deasserting valid without a handshake is legal; it is not granted.

Optional Feature:
- Macro: SET_ARB_WDOG_EN.
- With the macro defined:
  - A counter clears on entry to ISSUE and counts every cycle in ISSUE and WAIT.
  - On reaching WDOG_CYC - 1 the FSM goes to RESP with rsp_err=1 and rsp_candidate=0. job_cnt still increments on the handshake.
- Without the macro: no counter logic; rsp_err is constant 0 and the FSM waits indefinitely.

Test Plan:
- The engine is a behavioural model: busy high for 5 cycles after en, then valid for one cycle with a programmed candidate.
- Single job: req0 with central=24'h335577, radius=12'h332, mode=01, model candidate=8'd23 → eng_en 1 cycle after handshake; rsp_valid with rsp_id=0, rsp_candidate=23; job_cnt=1.
- Contention: req0 and req1 valid together continuously for 4 jobs → grant order 0,1,0,1; rsp_id sequence 0,1,0,1; job_cnt=4.
- Busy engine: eng_busy forced high for 10 cycles while in ISSUE → eng_en withheld; eng_en pulses exactly once, the cycle after busy falls.
- Backpressure: rsp_ready low for 7 cycles → rsp fields stable, no new grant, req0_ready stays 0; completes after rsp_ready goes high.
- Reset in WAIT: rst low for 1 cycle → all outputs 0 and pointer 0; a subsequent req1-only job gets rsp_id=1.
- SET_ARB_WDOG_EN with WDOG_CYC=16, model never asserts valid → rsp_valid after 16 cycles with rsp_err=1 and rsp_candidate=0.
